// File: rtl/df_pkg.sv
// Shared definitions for the CFNP dense layers: widths, FSM states and
// the 16-bit saturation helper.
package df_pkg;

  localparam int unsigned N_TAPS    = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_BITS = 11;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned PROD_W    = 2 * DATA_W;
  localparam int unsigned IDX_W     = $clog2(N_TAPS);
  localparam int unsigned VEC_W     = N_TAPS * DATA_W;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_FINAL,
    ST_DONE
  } df_state_t;

  typedef logic [N_TAPS-1:0][DATA_W-1:0] df_vec_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] y;
    logic                     sat;
  } df_result_t;

  // Clip a wide signed value into the 16-bit output range, flagging clipping.
  function automatic df_result_t sat16(input logic signed [ACC_W-1:0] v);
    df_result_t r;
    if (v > Y_MAX) begin
      r.y   = Y_MAX[DATA_W-1:0];
      r.sat = 1'b1;
    end else if (v < Y_MIN) begin
      r.y   = Y_MIN[DATA_W-1:0];
      r.sat = 1'b1;
    end else begin
      r.y   = v[DATA_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/df_layer_sequencer_if.sv
// Handshake bundle between the dense-layer sequencer, the feature buffer,
// the weight memory and the output stage.
interface df_layer_sequencer_if;
  import df_pkg::*;

  logic                     start;
  logic [VEC_W-1:0]         x_flat;
  logic                     w_start;
  logic [IDX_W-1:0]         w_idx;
  logic signed [DATA_W-1:0] w_in;
  logic                     w_done;
  logic signed [DATA_W-1:0] y;
  logic                     busy;
  logic                     done;
  logic                     sat;

  modport master (
    input  start, x_flat, w_in, w_done,
    output w_start, w_idx, y, busy, done, sat
  );

  modport slave (
    output start, x_flat, w_in, w_done,
    input  w_start, w_idx, y, busy, done, sat
  );

endinterface

// File: rtl/df_mac_unit.sv
// Signed 16x16 multiply into a 40-bit accumulator with clear and enable.
module df_mac_unit
  import df_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  assign prod = PROD_W'(a_i) * PROD_W'(b_i);

  // Clear wins over enable so a new inference never inherits a stale sum.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/df_layer_sequencer.sv
// Dense-layer sequencer: latches a feature vector, walks the weight memory
// through every tap, accumulates, then rounds, biases and saturates to 16 bits.
module df_layer_sequencer
  import df_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] BIAS = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  df_layer_sequencer_if.master bus_io
);

  localparam int RND_HALF = 2 ** (FRAC_BITS - 1);

  df_state_t                state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [IDX_W-1:0]         w_idx_q, w_idx_d;
  df_vec_t                  x_q, x_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     sat_q, sat_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     w_start_q, w_start_d;

  logic                     mac_clr;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  biased;
  df_result_t               res;

  df_mac_unit u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   ($signed(x_q[idx_q])),
    .b_i   (bus_io.w_in),
    .acc_o (acc)
  );

  // Round half up at the Q4.11 binary point, then bias and clip.
  always_comb begin
    rnd    = (acc + ACC_W'(RND_HALF)) >>> FRAC_BITS;
    biased = rnd + ACC_W'(BIAS);
    res    = sat16(biased);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    sat_d   = sat_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus_io.start) begin
          x_d     = df_vec_t'(bus_io.x_flat);
          idx_d   = '0;
          mac_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (bus_io.w_done) begin
          mac_en = 1'b1;
          if (idx_q == IDX_W'(N_TAPS - 1)) begin
            idx_d   = '0;
            state_d = ST_FINAL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_FINAL: begin
        y_d     = res.y;
        sat_d   = res.sat;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    w_start_d = (state_d == ST_MAC);
    w_idx_d   = (state_d == ST_MAC) ? idx_d : '0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      w_start_q <= 1'b0;
      w_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sat_q     <= sat_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      w_start_q <= w_start_d;
      w_idx_q   <= w_idx_d;
    end
  end

  assign bus_io.w_start = w_start_q;
  assign bus_io.w_idx   = w_idx_q;
  assign bus_io.y       = y_q;
  assign bus_io.sat     = sat_q;
  assign bus_io.done    = done_q;
  assign bus_io.busy    = busy_q;

endmodule

// File: tb/tb_df_layer_sequencer.sv
// Scoreboard bench for df_layer_sequencer: two instances (BIAS 0 and -5)
// share stimulus and a combinational weight-memory model.
module tb_df_layer_sequencer;
  import df_pkg::*;

  typedef struct {
    logic signed [DATA_W-1:0] y;
    logic                     sat;
    int                       acc;
    int                       sbase;
  } exp_t;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             rst_q   = 1'b0;
  logic             start_s = 1'b0;
  logic [VEC_W-1:0] x_s     = '0;
  logic             stall   = 1'b0;

  int cyc        = 0;
  int stall_cnt  = 0;
  int n_tests    = 0;
  int n_fail     = 0;
  int n_push     = 0;
  int exp_idx    = 0;
  int n_done[2]    = '{0, 0};
  int last_done[2] = '{-100, -100};
  bit finish_req = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  int WT[N_TAPS] = '{1941, 1945, 1940, 1945, 1942};

  df_layer_sequencer_if bus0 ();
  df_layer_sequencer_if bus1 ();

  df_layer_sequencer #(.BIAS(16'sd0)) dut0 (.clk(clk), .rst(rst), .bus_io(bus0));
  df_layer_sequencer #(.BIAS(-16'sd5)) dut1 (.clk(clk), .rst(rst), .bus_io(bus1));

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] wmem(input logic [IDX_W-1:0] idx);
    if (int'(idx) < N_TAPS) return DATA_W'(WT[idx]);
    return '0;
  endfunction

  assign bus0.start  = start_s;
  assign bus1.start  = start_s;
  assign bus0.x_flat = x_s;
  assign bus1.x_flat = x_s;
  assign bus0.w_in   = wmem(bus0.w_idx);
  assign bus1.w_in   = wmem(bus1.w_idx);
  assign bus0.w_done = bus0.w_start & ~stall;
  assign bus1.w_done = bus1.w_start & ~stall;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    if (bus0.w_start && stall) stall_cnt <= stall_cnt + 1;
  end

  // Reference: dot product, round half up at 2^11, bias, clip to 16 bits.
  function automatic exp_t model(input logic [VEC_W-1:0] xv, input int bias);
    exp_t   r;
    longint acc;
    longint v;
    acc = 0;
    for (int i = 0; i < N_TAPS; i++)
      acc += longint'($signed(xv[i*DATA_W +: DATA_W])) * WT[i];
    v = (acc + 1024) >>> 11;
    v = v + bias;
    r.sat = (v > 32767) || (v < -32768);
    if (v > 32767)       r.y = 16'sh7FFF;
    else if (v < -32768) r.y = 16'sh8000;
    else                 r.y = DATA_W'(v);
    r.acc   = 0;
    r.sbase = 0;
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] splat(input logic [DATA_W-1:0] v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_TAPS; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [VEC_W-1:0] xv, input int acc);
    exp_t a;
    exp_t b;
    a = model(xv, 0);
    b = model(xv, -5);
    a.acc = acc;       b.acc = acc;
    a.sbase = stall_cnt; b.sbase = stall_cnt;
    q0.push_back(a);
    q1.push_back(b);
    n_push++;
  endtask

  task automatic mon_dut(input int id, input logic done, input logic busy,
                         input logic signed [DATA_W-1:0] y, input logic sat);
    exp_t f;
    int   sz;
    sz = (id == 0) ? q0.size() : q1.size();
    if (sz > 0) f = (id == 0) ? q0[0] : q1[0];
    if (sz > 0 && cyc == f.acc)
      check($sformatf("busy_after_start%0d", id), busy, 1);
    if (cyc == last_done[id] + 1) begin
      check($sformatf("busy_after_done%0d", id), busy, 0);
      check($sformatf("done_one_cycle%0d", id), done, 0);
    end
    if (done) begin
      n_done[id]++;
      last_done[id] = cyc;
      check($sformatf("done_expected%0d", id), sz > 0, 1);
      if (sz > 0) begin
        if (id == 0) f = q0.pop_front(); else f = q1.pop_front();
        check($sformatf("y%0d", id), y, f.y);
        check($sformatf("sat%0d", id), sat, f.sat);
        check($sformatf("latency%0d", id), cyc - f.acc - (stall_cnt - f.sbase), 6);
        check($sformatf("busy_at_done%0d", id), busy, 1);
      end
    end else if (sz > 0 && cyc - f.acc > 60) begin
      check($sformatf("done_timeout%0d", id), cyc - f.acc, 6 + stall_cnt - f.sbase);
      if (id == 0) f = q0.pop_front(); else f = q1.pop_front();
    end
  endtask

  // Single checking process: reset values, weight index order, done/result scoreboard.
  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_outputs0", longint'({bus0.w_start, bus0.w_idx, bus0.y, bus0.done, bus0.busy, bus0.sat}), 0);
      check("rst_outputs1", longint'({bus1.w_start, bus1.w_idx, bus1.y, bus1.done, bus1.busy, bus1.sat}), 0);
      q0.delete();
      q1.delete();
      exp_idx = 0;
    end else begin
      if (bus0.w_start && bus0.w_done) begin
        check("w_idx_order", bus0.w_idx, exp_idx);
        exp_idx = (exp_idx + 1) % N_TAPS;
      end else if (!bus0.w_start) begin
        check("w_idx_idle", bus0.w_idx, 0);
      end
      mon_dut(0, bus0.done, bus0.busy, bus0.y, bus0.sat);
      mon_dut(1, bus1.done, bus1.busy, bus1.y, bus1.sat);
    end
    if (finish_req) begin
      check("done_count0", n_done[0], n_push);
      check("done_count1", n_done[1], n_push);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // mode: 0 plain, 1 random stalls, 2 stall at idx 2, 3 start while busy,
  //       4 reset in cycle 4, 5 start held for an immediate relaunch
  task automatic run(input logic [VEC_W-1:0] xv, input int mode);
    int acc;
    @(posedge clk); #1;
    start_s = 1'b1;
    x_s     = xv;
    acc     = cyc + 1;
    if (mode != 4) push(xv, acc);
    if (mode == 5) push(xv, acc + 8);
    @(posedge clk); #1;
    if (mode != 5) begin
      start_s = 1'b0;
      for (int i = 0; i < N_TAPS; i++) x_s[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    for (int k = 1; k < 150; k++) begin
      if (k >= 9 && q0.size() == 0 && q1.size() == 0) break;
      stall = 1'b0;
      case (mode)
        1: stall   = ($urandom_range(0, 3) == 0);
        2: stall   = (k == 3 || k == 4);
        3: start_s = (k == 3);
        4: rst     = (k == 4);
        5: start_s = (k <= 8);
        default: ;
      endcase
      @(posedge clk); #1;
    end
    stall   = 1'b0;
    start_s = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    logic [VEC_W-1:0] xv;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run(splat(16'd2048), 0);
    run(splat(-16'sd2048), 0);
    run(splat(16'sh7FFF), 0);
    run(splat(16'sh8000), 0);
    xv = '0;
    xv[0 +: DATA_W] = 16'd1;
    run(xv, 0);
    run('0, 0);
    run(splat(16'd2048), 2);
    run(splat(16'd2048), 3);
    run(splat(16'd2048), 4);
    run(splat(16'd2048), 0);
    run(splat(16'd2048), 5);
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < N_TAPS; i++)
        xv[i*DATA_W +: DATA_W] = (n % 2 == 0) ? DATA_W'($urandom)
                                              : DATA_W'($urandom_range(0, 4095) - 2048);
      run(xv, (n % 3 == 0) ? 0 : 1);
    end
    repeat (4) @(posedge clk);
    #1 finish_req = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
